// File: rtl/sha_alu_pipe.sv
// sha_alu_pipe: two-stage pipelined ALU for the SHA-256 datapath.
//
// Stage 1 registers the operation and its operands. Stage 2 evaluates the
// ALU from the stage-1 registers and loads the output register. A
// valid/ready handshake with backpressure holds up to two operations in
// flight. Results leave in acceptance order.
//
// Optional feature: define SHA_ALU_SIGMA_EN to build the SHA primitives
// CH, MAJ, BSIG0/1 and SSIG0/1 (opcodes 12-17). This requires WIDTH == 32.
// Without it those opcodes are reported as illegal.
//
// Parameters:
//   WIDTH      datapath width (>= 8)
//   SHAMT_W    shift amount width
// Ports:
//   clock, reset                   clock, async active-high reset
//   in_valid/in_ready              input handshake
//   in_opcode, in_a, in_b, in_c    operation and operands
//   in_shamt                       shift/rotate amount (taken modulo WIDTH)
//   out_valid/out_ready            output handshake
//   out_result                     registered result
//   out_ne, out_lt                 a != b, signed a < b
//   out_ovf, out_illegal           signed overflow (ADD/SUB), unsupported opcode
module sha_alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         in_opcode,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [WIDTH-1:0]   in_c,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_ne,
    output logic               out_lt,
    output logic               out_ovf,
    output logic               out_illegal
);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_SLL   = 5'd4;
    localparam logic [4:0] OP_SRA   = 5'd5;
    localparam logic [4:0] OP_XOR   = 5'd8;
    localparam logic [4:0] OP_ROTR  = 5'd9;
    localparam logic [4:0] OP_ADDU  = 5'd10;
    localparam logic [4:0] OP_SRL   = 5'd11;
`ifdef SHA_ALU_SIGMA_EN
    localparam logic [4:0] OP_CH    = 5'd12;
    localparam logic [4:0] OP_MAJ   = 5'd13;
    localparam logic [4:0] OP_BSIG0 = 5'd14;
    localparam logic [4:0] OP_BSIG1 = 5'd15;
    localparam logic [4:0] OP_SSIG0 = 5'd16;
    localparam logic [4:0] OP_SSIG1 = 5'd17;
`endif

    localparam int MSB = WIDTH - 1;
    localparam logic [SHAMT_W:0] WIDTH_L = (SHAMT_W + 1)'(WIDTH);

    if (WIDTH < 8) begin : g_width_chk
        $error("sha_alu_pipe: WIDTH must be at least 8");
    end
`ifdef SHA_ALU_SIGMA_EN
    if (WIDTH != 32) begin : g_sigma_chk
        $error("sha_alu_pipe: SHA_ALU_SIGMA_EN requires WIDTH == 32");
    end

    function automatic logic [WIDTH-1:0] rotr_c(input logic [WIDTH-1:0] x, input int n);
        return (x >> n) | (x << (WIDTH - n));
    endfunction
`endif

    logic               s1_valid_q, s1_valid_d;
    logic [4:0]         s1_op_q, s1_op_d;
    logic [WIDTH-1:0]   s1_a_q, s1_a_d;
    logic [WIDTH-1:0]   s1_b_q, s1_b_d;
    logic [SHAMT_W-1:0] s1_shamt_q, s1_shamt_d;
`ifdef SHA_ALU_SIGMA_EN
    logic [WIDTH-1:0]   s1_c_q, s1_c_d;
`else
    // in_c only feeds CH/MAJ, which are not built in this configuration.
    logic               unused_in_c;
    assign unused_in_c = ^in_c;
`endif

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_result_q, out_result_d;
    logic               out_ne_q, out_ne_d;
    logic               out_lt_q, out_lt_d;
    logic               out_ovf_q, out_ovf_d;
    logic               out_illegal_q, out_illegal_d;

    logic s1_load, s2_load;

    // The output register frees up in the same cycle it retires, so a full
    // pipe still accepts while the consumer is taking a result.
    assign in_ready = !s1_valid_q || !out_valid_q || out_ready;
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);

    // Stage-2 datapath
    logic [SHAMT_W-1:0] sh;
    logic [SHAMT_W:0]   sh_left;
    logic [WIDTH-1:0]   sum, diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf, alu_ill, alu_ne, alu_lt;

    always_comb begin
        sh      = SHAMT_W'(32'(s1_shamt_q) % 32'(WIDTH));
        sh_left = WIDTH_L - {1'b0, sh};
        sum     = s1_a_q + s1_b_q;
        diff    = s1_a_q - s1_b_q;
        alu_ne  = s1_a_q != s1_b_q;
        alu_lt  = $signed(s1_a_q) < $signed(s1_b_q);
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum[MSB] != s1_a_q[MSB]);
            end
            OP_SUB: begin
                // Same rule as ADD applied to a + ~b + 1.
                alu_res = diff;
                alu_ovf = (s1_a_q[MSB] != s1_b_q[MSB]) && (diff[MSB] != s1_a_q[MSB]);
            end
            OP_AND:  alu_res = s1_a_q & s1_b_q;
            OP_OR:   alu_res = s1_a_q | s1_b_q;
            OP_XOR:  alu_res = s1_a_q ^ s1_b_q;
            OP_SLL:  alu_res = s1_a_q << sh;
            OP_SRL:  alu_res = s1_a_q >> sh;
            OP_SRA:  alu_res = $unsigned($signed(s1_a_q) >>> sh);
            // A left shift by WIDTH yields zero, so a rotate by 0 returns a.
            OP_ROTR: alu_res = (s1_a_q >> sh) | (s1_a_q << sh_left);
            OP_ADDU: alu_res = sum;
`ifdef SHA_ALU_SIGMA_EN
            OP_CH:    alu_res = (s1_a_q & s1_b_q) ^ (~s1_a_q & s1_c_q);
            OP_MAJ:   alu_res = (s1_a_q & s1_b_q) ^ (s1_a_q & s1_c_q) ^ (s1_b_q & s1_c_q);
            OP_BSIG0: alu_res = rotr_c(s1_a_q, 2) ^ rotr_c(s1_a_q, 13) ^ rotr_c(s1_a_q, 22);
            OP_BSIG1: alu_res = rotr_c(s1_a_q, 6) ^ rotr_c(s1_a_q, 11) ^ rotr_c(s1_a_q, 25);
            OP_SSIG0: alu_res = rotr_c(s1_a_q, 7) ^ rotr_c(s1_a_q, 18) ^ (s1_a_q >> 3);
            OP_SSIG1: alu_res = rotr_c(s1_a_q, 17) ^ rotr_c(s1_a_q, 19) ^ (s1_a_q >> 10);
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    // Next-state for both stages
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_op_d       = s1_op_q;
        s1_a_d        = s1_a_q;
        s1_b_d        = s1_b_q;
        s1_shamt_d    = s1_shamt_q;
`ifdef SHA_ALU_SIGMA_EN
        s1_c_d        = s1_c_q;
`endif
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_ne_d      = out_ne_q;
        out_lt_d      = out_lt_q;
        out_ovf_d     = out_ovf_q;
        out_illegal_d = out_illegal_q;

        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_op_d    = in_opcode;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_shamt_d = in_shamt;
`ifdef SHA_ALU_SIGMA_EN
            s1_c_d     = in_c;
`endif
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            out_valid_d   = 1'b1;
            out_result_d  = alu_res;
            out_ne_d      = alu_ne;
            out_lt_d      = alu_lt;
            out_ovf_d     = alu_ovf;
            out_illegal_d = alu_ill;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            s1_op_q       <= '0;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            s1_shamt_q    <= '0;
`ifdef SHA_ALU_SIGMA_EN
            s1_c_q        <= '0;
`endif
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_ne_q      <= 1'b0;
            out_lt_q      <= 1'b0;
            out_ovf_q     <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_op_q       <= s1_op_d;
            s1_a_q        <= s1_a_d;
            s1_b_q        <= s1_b_d;
            s1_shamt_q    <= s1_shamt_d;
`ifdef SHA_ALU_SIGMA_EN
            s1_c_q        <= s1_c_d;
`endif
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_ne_q      <= out_ne_d;
            out_lt_q      <= out_lt_d;
            out_ovf_q     <= out_ovf_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_ne      = out_ne_q;
    assign out_lt      = out_lt_q;
    assign out_ovf     = out_ovf_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_sha_alu_pipe.sv
// Testbench for sha_alu_pipe: directed vectors, backpressure, streaming,
// async reset with work in flight, and a randomized run checked against
// an arithmetic reference model through an in-order scoreboard.
module tb_sha_alu_pipe;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_opcode;
    logic [W-1:0]  in_a, in_b, in_c;
    logic [SW-1:0] in_shamt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_ne, out_lt, out_ovf, out_illegal;

    always #5 clock = ~clock;

    sha_alu_pipe #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_c        (in_c),
        .in_shamt    (in_shamt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_ne      (out_ne),
        .out_lt      (out_lt),
        .out_ovf     (out_ovf),
        .out_illegal (out_illegal)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
        logic [2*W-1:0] t;
        t = {x, x} >> n;
        return t[W-1:0];
    endfunction

    // Returns {result, ne, lt, ovf, illegal}
    function automatic logic [W+3:0] ref_alu(input logic [4:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] c,
                                             input logic [SW-1:0] shamt);
        longint sa, sb, t, smax, smin;
        int s;
        logic [W-1:0] r;
        logic ovf, ill;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        s    = int'(shamt) % W;
        r    = '0;
        ovf  = 1'b0;
        ill  = 1'b0;
        t    = 0;
        case (op)
            5'd0:  begin t = sa + sb; r = t[W-1:0]; ovf = (t > smax) || (t < smin); end
            5'd1:  begin t = sa - sb; r = t[W-1:0]; ovf = (t > smax) || (t < smin); end
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a << s;
            5'd5:  begin t = sa >>> s; r = t[W-1:0]; end
            5'd8:  r = a ^ b;
            5'd9:  r = rotr(a, s);
            5'd10: begin t = longint'(a) + longint'(b); r = t[W-1:0]; end
            5'd11: r = a >> s;
`ifdef SHA_ALU_SIGMA_EN
            5'd12: for (int i = 0; i < W; i++) r[i] = a[i] ? b[i] : c[i];
            5'd13: for (int i = 0; i < W; i++) r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
            5'd14: r = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
            5'd15: r = rotr(a, 6) ^ rotr(a, 11) ^ rotr(a, 25);
            5'd16: r = rotr(a, 7) ^ rotr(a, 18) ^ (a >> 3);
            5'd17: r = rotr(a, 17) ^ rotr(a, 19) ^ (a >> 10);
`endif
            default: ill = 1'b1;
        endcase
        return {r, a != b, sa < sb, ovf, ill};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    int            cyc = 0;
    logic [W+3:0]  exp_q[$];
    int            acc_q[$];
    int            ret_cyc[$];
    logic [W-1:0]  ret_val[$];
    int            n_ret = 0;
    bit            stream_mode = 1'b0;
    logic [W-1:0]  last_res;
    logic [3:0]    last_flg;
    logic [W+3:0]  sb_exp;
    int            sb_acc;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    sb_exp = exp_q.pop_front();
                    sb_acc = acc_q.pop_front();
                    check("sb_result", 64'({out_result, out_ne, out_lt, out_ovf, out_illegal}), 64'(sb_exp));
                    if (stream_mode) check("latency", 64'(cyc - sb_acc), 64'd2);
                end
                n_ret++;
                last_res = out_result;
                last_flg = {out_ne, out_lt, out_ovf, out_illegal};
                ret_cyc.push_back(cyc);
                ret_val.push_back(out_result);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_alu(in_opcode, in_a, in_b, in_c, in_shamt));
                acc_q.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [SW-1:0] sh, output int waited);
        logic ok;
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        in_c      = c;
        in_shamt  = sh;
        waited    = 0;
        ok        = 1'b0;
        while (!ok && waited < 50) begin
            @(negedge clock);
            ok = in_ready;
            @(posedge clock);
            #1;
            waited++;
        end
        check("accept", 64'(ok), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic run_dir(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] c, input logic [SW-1:0] sh,
                           input logic [W-1:0] exp_r, input logic [3:0] exp_f);
        int n0, w;
        n0 = n_ret;
        issue(op, a, b, c, sh, w);
        for (int i = 0; i < 10 && n_ret == n0; i++) @(posedge clock);
        #1;
        check({tag, "_done"}, 64'(n_ret > n0), 64'd1);
        check({tag, "_res"}, 64'(last_res), 64'(exp_r));
        check({tag, "_flags"}, 64'(last_flg), 64'(exp_f));
    endtask

    logic [4:0] legal_ops [16];
    int w;
    int n0;

    initial begin
        legal_ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8, 5'd9,
                      5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17};
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_a      = '0;
        in_b      = '0;
        in_c      = '0;
        in_shamt  = '0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_flags", 64'({out_ne, out_lt, out_ovf, out_illegal}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clock);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;

        // ---- directed vectors ({ne,lt,ovf,ill} flags) ----
        run_dir("add_ovf",  5'd0,  32'h7FFFFFFF, 32'h00000001, '0, '0, 32'h80000000, 4'b1010);
        run_dir("addu",     5'd10, 32'h7FFFFFFF, 32'h00000001, '0, '0, 32'h80000000, 4'b1000);
        run_dir("sub_ovf",  5'd1,  32'h80000000, 32'h00000001, '0, '0, 32'h7FFFFFFF, 4'b1110);
        run_dir("rotr1",    5'd9,  32'h00000001, 32'h0,        '0, 5'd1, 32'h80000000, 4'b1000);
        run_dir("rotr0",    5'd9,  32'h12345678, 32'h0,        '0, 5'd0, 32'h12345678, 4'b1000);
        run_dir("sra4",     5'd5,  32'h80000000, 32'h0,        '0, 5'd4, 32'hF8000000, 4'b1100);
        run_dir("sll31",    5'd4,  32'h00000001, 32'h0,        '0, 5'd31, 32'h80000000, 4'b1000);
        run_dir("illegal6", 5'd6,  32'h00000005, 32'h00000005, '0, '0, 32'h0, 4'b0001);
`ifdef SHA_ALU_SIGMA_EN
        run_dir("bsig0", 5'd14, 32'h00000001, 32'h0, '0, '0, 32'h40080400, 4'b1000);
        run_dir("ssig0", 5'd16, 32'h00000001, 32'h0, '0, '0, 32'h02004000, 4'b1000);
        run_dir("ch",    5'd12, 32'hFFFF0000, 32'h12345678, 32'h9ABCDEF0, '0, 32'h1234DEF0, 4'b1100);
        run_dir("maj",   5'd13, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0F0F0F0F, '0, 32'hFF00FF00, 4'b1100);
`else
        run_dir("bsig0_off", 5'd14, 32'h00000001, 32'h0, '0, '0, 32'h0, 4'b1001);
        run_dir("maj_off",   5'd13, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0F0F0F0F, '0, 32'h0, 4'b1101);
`endif

        // ---- backpressure ----
        out_ready = 1'b0;
        n0 = n_ret;
        issue(5'd0, 32'd1, 32'd1, '0, '0, w);
        check("bp_acc1", 64'(w), 64'd1);
        issue(5'd0, 32'd2, 32'd2, '0, '0, w);
        check("bp_acc2", 64'(w), 64'd1);
        in_valid  = 1'b1;
        in_opcode = 5'd0;
        in_a      = 32'd3;
        in_b      = 32'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_hold", 64'(out_result), 64'd2);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(negedge clock);
        check("bp_release_ready", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("bp_count", 64'(n_ret - n0), 64'd3);
        if (n_ret - n0 == 3) begin
            check("bp_r0", 64'(ret_val[n0]), 64'd2);
            check("bp_r1", 64'(ret_val[n0+1]), 64'd4);
            check("bp_r2", 64'(ret_val[n0+2]), 64'd6);
            check("bp_consec0", 64'(ret_cyc[n0+1] - ret_cyc[n0]), 64'd1);
            check("bp_consec1", 64'(ret_cyc[n0+2] - ret_cyc[n0+1]), 64'd1);
        end

        // ---- streaming ----
        stream_mode = 1'b1;
        n0 = n_ret;
        for (int i = 0; i < 16; i++) begin
            issue(legal_ops[$urandom_range(0, 15)], $urandom, $urandom, $urandom,
                  SW'($urandom_range(0, W - 1)), w);
            check("stream_accept_1cyc", 64'(w), 64'd1);
        end
        repeat (4) @(posedge clock);
        #1;
        stream_mode = 1'b0;
        check("stream_count", 64'(n_ret - n0), 64'd16);
        if (n_ret - n0 == 16) begin
            for (int i = 1; i < 16; i++)
                check("stream_consec", 64'(ret_cyc[n0+i] - ret_cyc[n0+i-1]), 64'd1);
        end

        // ---- reset with two operations in flight ----
        out_ready = 1'b0;
        issue(5'd0, 32'd5, 32'd5, '0, '0, w);
        issue(5'd0, 32'd7, 32'd7, '0, '0, w);
        #3;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'd0);
        check("rst_async_result", 64'(out_result), 64'd0);
        check("rst_async_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clock);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        n0 = n_ret;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("rst_no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clock);
        #1;
        check("rst_no_retire", 64'(n_ret - n0), 64'd0);

        // ---- randomized traffic ----
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_opcode = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 15)]
                                                    : 5'($urandom_range(0, 31));
            in_a      = $urandom;
            in_b      = ($urandom_range(0, 7) == 0) ? in_a : $urandom;
            in_c      = $urandom;
            in_shamt  = SW'($urandom_range(0, W - 1));
            if ($urandom_range(0, 9) == 0) in_a = 32'h7FFFFFFF;
            if ($urandom_range(0, 9) == 0) in_b = 32'h80000000;
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clock);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("drain_idle", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sha_alu_pipe.md
# sha_alu_pipe

Parametrised, two-stage pipelined ALU for the SHA-256 datapath. It is the successor to the single-cycle combinational ALU and keeps its opcode map and flag outputs. New over the old ALU: configurable width, a valid/ready handshake with backpressure, signed overflow detection, and three-operand SHA primitives (CH, MAJ, and the four sigma functions). It sits between the message-schedule/compression control FSM and the register file writeback.

## Interface
- `WIDTH`, 32: datapath width in bits; must be ≥ 8.
- `SHAMT_W`, `$clog2(WIDTH)`: width of the shift amount.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all valid bits and output registers.
- `in_valid` in 1: operation presented this cycle.
- `in_ready` out 1: stage 1 accepts the operation when `in_valid && in_ready`.
- `in_opcode` in 5: operation select.
- `in_a`, `in_b`, `in_c` in WIDTH each: operands; `in_c` is used only by CH and MAJ.
- `in_shamt` in SHAMT_W: shift/rotate amount.
- `out_valid` out 1: result is valid.
- `out_ready` in 1: the consumer accepts the result when `out_valid && out_ready`.
- `out_result` out WIDTH: result.
- `out_ne` out 1: `a != b`.
- `out_lt` out 1: signed `a < b`.
- `out_ovf` out 1: signed overflow; ADD and SUB only.
- `out_illegal` out 1: the opcode is unsupported.

## Operation
- Opcodes:
  - 0 ADD
  - 1 SUB
  - 2 AND
  - 3 OR
  - 4 SLL
  - 5 SRA
  - 8 XOR
  - 9 ROTR by `shamt`
  - 10 ADDU: modulo 2^WIDTH; `ovf` = 0
  - 11 SRL
  - 12 CH = `(a&b)^(~a&c)`
  - 13 MAJ = `(a&b)^(a&c)^(b&c)`
  - 14 BSIG0 = `ROTR2^ROTR13^ROTR22 (a)`
  - 15 BSIG1 = `ROTR6^ROTR11^ROTR25 (a)`
  - 16 SSIG0 = `ROTR7^ROTR18^SHR3 (a)`
  - 17 SSIG1 = `ROTR17^ROTR19^SHR10 (a)`
- All other opcodes are illegal: `result` = 0, `ovf` = 0, `illegal` = 1; `ne`/`lt` are still computed.
- ADD/SUB overflow rule: set when the operand signs (for SUB, the sign of `a` and of the inverted `b`) agree and the result sign differs. For all other legal opcodes `ovf` = 0.
- Shift/rotate amount:
  - `shamt` is used modulo WIDTH.
  - ROTR by 0 returns `a`.
  - SRA fills with `a[WIDTH-1]`; SRL and SLL fill with 0.
- Stage 1 (S1): registers `opcode`, `a`, `b`, `c`, `shamt`; asserts `s1_valid`.
- Stage 2 (S2): computes combinationally from S1 and registers `result`/flags into the output register; `out_valid` follows.
- Advance rules:
  - S2 loads when `s1_valid && (!out_valid || out_ready)`.
  - S1 loads when `in_valid && in_ready`.
  - `in_ready = !s1_valid || (!out_valid || out_ready)`. Bubbles collapse.
- Ordering: results leave strictly in acceptance order. There is no reordering and no drop.
- While stalled (`out_valid && !out_ready`), `out_*` and S1 contents hold stable.
- Outputs are fully registered. `in_ready` is the only combinational path, from `out_ready`.

## Timing
- Latency: an operation accepted at edge N appears with `out_valid` = 1 after edge N+1, provided there is no stall. Throughput is one operation per cycle.
- Capacity: 2 operations in flight, one in S1 and one in the output register. With `out_ready` held low, `in_ready` falls after two acceptances.
- Accept and retire in the same cycle: both happen; occupancy is unchanged.
- Reset values: `out_valid` = 0, `out_result` = 0, `out_ne` = `out_lt` = `out_ovf` = `out_illegal` = 0, `s1_valid` = 0. `in_ready` = 1 while `reset` is high and after its release.
- Reset mid-operation: in-flight operations are discarded. No output pulse appears after `reset` deasserts until new input is accepted.

## Configuration
- `SHA_ALU_SIGMA_EN` defined:
  - Opcodes 12–17 are implemented as above.
  - An elaboration-time check requires `WIDTH == 32` and errors otherwise.
- `SHA_ALU_SIGMA_EN` undefined:
  - Opcodes 12–17 are illegal: `result` = 0, `illegal` = 1.
  - No sigma/CH/MAJ logic is synthesised, and any WIDTH is allowed.

## Test plan
- ADD with `a` = 0x7FFFFFFF, `b` = 0x00000001 → `result` 0x80000000, `ovf` = 1, `lt` = 0, `ne` = 1. The same operands with ADDU give `ovf` = 0.
- ROTR `a` = 0x00000001, `shamt` = 1 → 0x80000000. SRA `a` = 0x80000000, `shamt` = 4 → 0xF8000000. Opcode 6 → `result` 0, `illegal` = 1.
- With the macro defined:
  - BSIG0(0x00000001) → 0x40080400.
  - SSIG0(0x00000001) → 0x02004000.
  - CH(0xFFFF0000, 0x12345678, 0x9ABCDEF0) → 0x1234DEF0.
  - MAJ(0xF0F0F0F0, 0xFF00FF00, 0x0F0F0F0F) → 0xFF00FF00.
- Backpressure:
  - With `out_ready` = 0, issue ADDs 1+1, 2+2, 3+3.
  - `in_ready` drops after the second acceptance and the third operation is held.
  - Then raise `out_ready`: the results 2, 4, 6 emerge in order on consecutive cycles, with `out_result` stable throughout the stall.
- Streaming: 16 back-to-back operations with `out_ready` = 1 → 16 results on 16 consecutive cycles. The first result appears one cycle after the first acceptance.
- Assert `reset` asynchronously with 2 operations in flight → `out_valid` drops immediately, no stale result appears afterwards, and `in_ready` = 1.
